// File: rtl/or1k_pkg.sv
// Shared OR1K types and constants used by the pipeline control blocks.
package or1k_pkg;

  // Branch PC to not-taken successor, delay slot included.
  localparam int OR1K_FALLTHROUGH_OFFSET = 8;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_DECODED,
    BR_WAIT_FLAG,
    BR_RESOLVE
  } br_state_e;

  function automatic logic branch_taken(input logic is_bf, input logic flag);
    return is_bf ? flag : ~flag;
  endfunction

endpackage

// File: rtl/or1k-defines.sv
// Shared OR1K build-time defines; guarded so every unit may include it.
// Define OR1K_BRANCH_STATS_EN to add the branch resolver statistics counters.
`ifndef OR1K_DEFINES_SV
`define OR1K_DEFINES_SV

`define OR1K_INSN_WIDTH 32

`endif

// File: rtl/or1k_branch_resolver.sv
// Tracks one conditional branch (l.bf / l.bnf) from decode to flag resolution and reports mispredictions.
// Optional macro OR1K_BRANCH_STATS_EN adds resolved/mispredicted branch counters.
`include "or1k-defines.sv"

module or1k_branch_resolver
  import or1k_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int FALLTHROUGH_OFFSET   = OR1K_FALLTHROUGH_OFFSET
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_decode_i,
  input  logic                            op_bf_i,
  input  logic                            op_bnf_i,
  input  logic                            predicted_flag_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] pc_decode_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] branch_target_i,
  input  logic                            padv_execute_i,
  input  logic                            flag_i,
  input  logic                            flag_valid_i,
  input  logic                            pipeline_flush_i,
  output logic                            stall_o,
  output logic                            branch_resolved_o,
  output logic                            mispredict_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o
`ifdef OR1K_BRANCH_STATS_EN
  ,
  output logic [31:0]                     stat_branches_o,
  output logic [31:0]                     stat_mispredicts_o
`endif
);

  localparam logic [OPTION_OPERAND_WIDTH-1:0] FT_OFFSET = OPTION_OPERAND_WIDTH'(FALLTHROUGH_OFFSET);

  br_state_e                        state_q, state_d;
  logic                             is_bf_q, is_bf_d;
  logic                             pred_q, pred_d;
  logic                             taken_q, taken_d;
  logic [OPTION_OPERAND_WIDTH-1:0]  pc_q, pc_d;
  logic [OPTION_OPERAND_WIDTH-1:0]  target_q, target_d;
  logic [OPTION_OPERAND_WIDTH-1:0]  redirect_q, redirect_d;
  logic                             branch_in;
  logic                             capture_en;
  logic                             resolve_en;
  logic                             taken_now;

  assign branch_in = padv_decode_i & (op_bf_i | op_bnf_i);

  // Flush overrides every transition, including a capture or resolution in the same cycle.
  always_comb begin
    state_d    = state_q;
    capture_en = 1'b0;
    resolve_en = 1'b0;
    case (state_q)
      BR_IDLE: begin
        if (branch_in) begin
          state_d    = BR_DECODED;
          capture_en = 1'b1;
        end
      end
      BR_DECODED: begin
        if (padv_execute_i) begin
          if (flag_valid_i) begin
            state_d    = BR_RESOLVE;
            resolve_en = 1'b1;
          end else begin
            state_d = BR_WAIT_FLAG;
          end
        end
      end
      BR_WAIT_FLAG: begin
        if (flag_valid_i) begin
          state_d    = BR_RESOLVE;
          resolve_en = 1'b1;
        end
      end
      BR_RESOLVE: begin
        if (branch_in) begin
          state_d    = BR_DECODED;
          capture_en = 1'b1;
        end else begin
          state_d = BR_IDLE;
        end
      end
      default: state_d = BR_IDLE;
    endcase
    if (pipeline_flush_i) begin
      state_d    = BR_IDLE;
      capture_en = 1'b0;
      resolve_en = 1'b0;
    end
  end

  assign taken_now = branch_taken(is_bf_q, flag_i);

  always_comb begin
    is_bf_d    = is_bf_q;
    pred_d     = pred_q;
    pc_d       = pc_q;
    target_d   = target_q;
    taken_d    = taken_q;
    redirect_d = redirect_q;
    if (capture_en) begin
      // A simultaneous bf/bnf encoding is resolved as bf.
      is_bf_d  = op_bf_i;
      pred_d   = predicted_flag_i;
      pc_d     = pc_decode_i;
      target_d = branch_target_i;
    end
    if (resolve_en) begin
      taken_d    = taken_now;
      redirect_d = taken_now ? target_q : pc_q + FT_OFFSET;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BR_IDLE;
      is_bf_q    <= 1'b0;
      pred_q     <= 1'b0;
      taken_q    <= 1'b0;
      pc_q       <= '0;
      target_q   <= '0;
      redirect_q <= '0;
    end else begin
      state_q    <= state_d;
      is_bf_q    <= is_bf_d;
      pred_q     <= pred_d;
      taken_q    <= taken_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      redirect_q <= redirect_d;
    end
  end

  assign stall_o           = (state_q == BR_WAIT_FLAG);
  assign branch_resolved_o = (state_q == BR_RESOLVE) & ~pipeline_flush_i;
  assign mispredict_o      = branch_resolved_o & (taken_q ^ pred_q);
  assign redirect_pc_o     = redirect_q;

`ifdef OR1K_BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_mispredicts_q;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (branch_resolved_o) stat_branches_q <= stat_branches_q + 32'd1;
      if (mispredict_o)      stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_branches_o    = stat_branches_q;
  assign stat_mispredicts_o = stat_mispredicts_q;
`else
  // Statistics disabled: no counter ports or registers.
`endif

endmodule

// File: tb/tb_or1k_branch_resolver.sv
// Self-checking bench for or1k_branch_resolver: directed corner cases plus randomized back-to-back branches
// checked against a transaction-level model of branch outcome, redirect PC and stall length.
module tb_or1k_branch_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        padv_decode_i, op_bf_i, op_bnf_i, predicted_flag_i;
  logic [31:0] pc_decode_i, branch_target_i;
  logic        padv_execute_i, flag_i, flag_valid_i, pipeline_flush_i;
  logic        stall_o, branch_resolved_o, mispredict_o;
  logic [31:0] redirect_pc_o;
`ifdef OR1K_BRANCH_STATS_EN
  logic [31:0] stat_branches_o, stat_mispredicts_o;
`endif

  or1k_branch_resolver dut (
    .clk               (clk),
    .rst               (rst),
    .padv_decode_i     (padv_decode_i),
    .op_bf_i           (op_bf_i),
    .op_bnf_i          (op_bnf_i),
    .predicted_flag_i  (predicted_flag_i),
    .pc_decode_i       (pc_decode_i),
    .branch_target_i   (branch_target_i),
    .padv_execute_i    (padv_execute_i),
    .flag_i            (flag_i),
    .flag_valid_i      (flag_valid_i),
    .pipeline_flush_i  (pipeline_flush_i),
    .stall_o           (stall_o),
    .branch_resolved_o (branch_resolved_o),
    .mispredict_o      (mispredict_o),
    .redirect_pc_o     (redirect_pc_o)
`ifdef OR1K_BRANCH_STATS_EN
    ,
    .stat_branches_o   (stat_branches_o),
    .stat_mispredicts_o(stat_mispredicts_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Pending branch transaction.
  logic        brBf, brBoth, brPred, brFlag;
  logic [31:0] brPc, brTarget;
  int          brWait;
  int          modelBranches = 0;
  int          modelMispredicts = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    padv_decode_i    = 1'b0;
    op_bf_i          = 1'b0;
    op_bnf_i         = 1'b0;
    predicted_flag_i = 1'b0;
    pc_decode_i      = 32'h0;
    branch_target_i  = 32'h0;
    padv_execute_i   = 1'b0;
    flag_i           = 1'b0;
    flag_valid_i     = 1'b0;
    pipeline_flush_i = 1'b0;
  endtask

  task automatic setBranch(input logic bf, input logic pred, input logic [31:0] pc,
                           input logic [31:0] target, input logic flag, input int waitCycles);
    brBf = bf; brBoth = 1'b0; brPred = pred; brPc = pc; brTarget = target; brFlag = flag; brWait = waitCycles;
  endtask

  task automatic newBranch();
    brBf     = 1'($urandom);
    brBoth   = brBf & 1'($urandom);
    brPred   = 1'($urandom);
    brFlag   = 1'($urandom);
    brPc     = $urandom;
    brTarget = $urandom;
    brWait   = int'($urandom_range(0, 3));
  endtask

  task automatic driveDecode();
    padv_decode_i    = 1'b1;
    op_bf_i          = brBf;
    op_bnf_i         = ~brBf | brBoth;
    predicted_flag_i = brPred;
    pc_decode_i      = brPc;
    branch_target_i  = brTarget;
  endtask

  // Caller has driven the decode of the pending branch in the current cycle.
  task automatic applyStimulus(input bit chainNext, input bit injectErr);
    logic        expTaken, expMis;
    logic [31:0] expRedirect;
    int          waitCycles;
    expTaken    = brBf ? brFlag : ~brFlag;
    expMis      = (expTaken != brPred);
    expRedirect = expTaken ? brTarget : brPc + 32'd8;
    waitCycles  = brWait;

    tick();
    clearInputs();
    if (injectErr) begin
      padv_decode_i    = 1'b1;
      op_bf_i          = 1'b1;
      predicted_flag_i = ~brPred;
      pc_decode_i      = ~brPc;
      branch_target_i  = ~brTarget;
    end
    padv_execute_i = 1'b1;
    flag_valid_i   = (waitCycles == 0);
    flag_i         = (waitCycles == 0) ? brFlag : 1'($urandom);
    #2;
    checkOutput("decodedStall", 32'(stall_o), 32'd0);
    checkOutput("decodedPulse", 32'(branch_resolved_o), 32'd0);

    for (int k = 1; k <= waitCycles; k++) begin
      tick();
      clearInputs();
      flag_valid_i = (k == waitCycles);
      flag_i       = (k == waitCycles) ? brFlag : 1'($urandom);
      #2;
      checkOutput("waitStall", 32'(stall_o), 32'd1);
      checkOutput("waitPulse", 32'(branch_resolved_o), 32'd0);
    end

    tick();
    clearInputs();
    modelBranches++;
    if (expMis) modelMispredicts++;
    if (chainNext) begin
      newBranch();
      driveDecode();
    end
    #2;
    checkOutput("resolvedPulse", 32'(branch_resolved_o), 32'd1);
    checkOutput("mispredict", 32'(mispredict_o), 32'(expMis));
    checkOutput("resolveStall", 32'(stall_o), 32'd0);
    if (expMis) checkOutput("redirectPc", redirect_pc_o, expRedirect);

    if (!chainNext) begin
      tick();
      clearInputs();
      #2;
      checkOutput("pulseEnds", 32'(branch_resolved_o), 32'd0);
      checkOutput("mispredictEnds", 32'(mispredict_o), 32'd0);
      if (expMis) checkOutput("redirectHold", redirect_pc_o, expRedirect);
    end
  endtask

  initial begin
    bit chain;
    logic taken;
    clearInputs();
    rst = 1'b1;
    #12;
    checkOutput("resetPulse", 32'(branch_resolved_o), 32'd0);
    checkOutput("resetMispredict", 32'(mispredict_o), 32'd0);
    checkOutput("resetStall", 32'(stall_o), 32'd0);
    checkOutput("resetRedirect", redirect_pc_o, 32'h0);
`ifdef OR1K_BRANCH_STATS_EN
    checkOutput("resetStatBranches", stat_branches_o, 32'd0);
    checkOutput("resetStatMispredicts", stat_mispredicts_o, 32'd0);
`endif
    rst = 1'b0;
    tick();

    $display("[TB] directed branches");
    setBranch(1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 0);
    driveDecode();
    applyStimulus(1'b0, 1'b0);
    setBranch(1'b0, 1'b0, 32'h200, 32'h300, 1'b0, 0);
    driveDecode();
    applyStimulus(1'b0, 1'b0);
    setBranch(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1234, 1'b0, 0);
    driveDecode();
    applyStimulus(1'b0, 1'b0);
    setBranch(1'b1, 1'b0, 32'h400, 32'h500, 1'b1, 3);
    driveDecode();
    applyStimulus(1'b0, 1'b0);
    setBranch(1'b1, 1'b0, 32'h480, 32'h520, 1'b1, 1);
    brBoth = 1'b1;
    driveDecode();
    applyStimulus(1'b0, 1'b0);
    setBranch(1'b0, 1'b1, 32'h600, 32'h700, 1'b1, 1);
    driveDecode();
    applyStimulus(1'b0, 1'b1);

    $display("[TB] flush cases");
    setBranch(1'b1, 1'b0, 32'h900, 32'hA00, 1'b1, 2);
    driveDecode();
    tick();
    clearInputs();
    padv_execute_i = 1'b1;
    tick();
    clearInputs();
    pipeline_flush_i = 1'b1;
    flag_valid_i     = 1'b1;
    flag_i           = 1'b1;
    tick();
    clearInputs();
    padv_execute_i = 1'b1;
    flag_valid_i   = 1'b1;
    #2;
    checkOutput("flushIdleStall", 32'(stall_o), 32'd0);
    checkOutput("flushIdlePulse", 32'(branch_resolved_o), 32'd0);
    tick();
    clearInputs();
    #2;
    checkOutput("flushNoPulse", 32'(branch_resolved_o), 32'd0);
    checkOutput("flushRedirectHold", redirect_pc_o, 32'h608);

    driveDecode();
    pipeline_flush_i = 1'b1;
    tick();
    clearInputs();
    padv_execute_i = 1'b1;
    flag_valid_i   = 1'b1;
    tick();
    clearInputs();
    #2;
    checkOutput("flushCapturePulse", 32'(branch_resolved_o), 32'd0);

    $display("[TB] randomized branches");
    newBranch();
    driveDecode();
    for (int i = 0; i < 12; i++) begin
      chain = (i < 11) && ($urandom_range(0, 1) == 1);
      applyStimulus(chain, 1'b0);
      if (!chain && i < 11) begin
        newBranch();
        driveDecode();
      end
    end

    $display("[TB] reset in DECODED");
    setBranch(1'b1, 1'b1, 32'hC00, 32'hD00, 1'b0, 0);
    driveDecode();
    tick();
    clearInputs();
    padv_execute_i = 1'b1;
    flag_valid_i   = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("asyncResetPulse", 32'(branch_resolved_o), 32'd0);
    checkOutput("asyncResetMispredict", 32'(mispredict_o), 32'd0);
    checkOutput("asyncResetStall", 32'(stall_o), 32'd0);
    checkOutput("asyncResetRedirect", redirect_pc_o, 32'h0);
    modelBranches    = 0;
    modelMispredicts = 0;
    tick();
    rst = 1'b0;
    #2;
    checkOutput("postResetPulse", 32'(branch_resolved_o), 32'd0);
    tick();
    clearInputs();
    #2;
    checkOutput("postResetPulse2", 32'(branch_resolved_o), 32'd0);

    $display("[TB] five branches, two mispredicted");
    for (int i = 0; i < 5; i++) begin
      newBranch();
      taken  = brBf ? brFlag : ~brFlag;
      brPred = (i < 2) ? ~taken : taken;
      driveDecode();
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("modelBranchCount", 32'(modelBranches), 32'd5);
    checkOutput("modelMispredictCount", 32'(modelMispredicts), 32'd2);
`ifdef OR1K_BRANCH_STATS_EN
    checkOutput("statBranches", stat_branches_o, 32'(modelBranches));
    checkOutput("statMispredicts", stat_mispredicts_o, 32'(modelMispredicts));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
